fifo_stream_adapter: RTL and testbench

- Sits directly upstream and downstream of the 8-slot ring FIFO, owning its command port.
- Converts a valid/ready write stream and a valid/ready read stream into the FIFO's single en / r_w command interface.
- Tracks occupancy locally, because the FIFO exposes no full/empty flags.
- Captures the FIFO's registered read data into a 2-entry skid buffer.
- Generates the FIFO's synchronous active-high reset.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_stream_adapter_chk.sv | 20 ++
 rtl/fifo_stream_adapter_skid_buffer.sv | 64 ++++++
 rtl/fifo_stream_adapter.sv | 128 ++++++++++++
 tb/tb_fifo_stream_adapter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the ring FIFO and the stream adapter that drives its command port.
package fifo_pkg;
    localparam int FIFO_SLOTS = 8;
    localparam int DEPTH      = FIFO_SLOTS - 1;

    typedef logic [31:0] word_t;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} adapter_state_e;
    typedef enum logic {PRIO_WRITE = 1'b0, PRIO_READ = 1'b1} prio_e;
endpackage

// File: rtl/fifo_stream_adapter_chk.sv
// Occupancy checker for fifo_stream_adapter: count stays in [0, DEPTH] and moves by at most one per cycle.
module fifo_stream_adapter_chk #(
    parameter  int DEPTH = 7,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          reset,
    input logic [CW-1:0] count
);
    localparam logic [CW-1:0] DEPTH_L = DEPTH[CW-1:0];
    localparam logic [CW-1:0] ONE_L   = {{(CW-1){1'b0}}, 1'b1};

    count_bounded_a: assert property (@(posedge clk) disable iff (!reset) count <= DEPTH_L);

    // a single-step rule also catches a wrap past 0 or DEPTH, which a bound alone cannot see
    count_step_a: assert property (@(posedge clk) disable iff (!reset)
        (count == $past(count)) ||
        ((count == $past(count) + ONE_L) && ($past(count) != DEPTH_L)) ||
        ((count == $past(count) - ONE_L) && ($past(count) != {CW{1'b0}})));
endmodule

// File: rtl/fifo_stream_adapter_skid_buffer.sv
// In-order skid buffer of SKID words; the head always sits in slot 0 so out_data is a plain register.
module skid_buffer #(
    parameter  int DW   = 32,
    parameter  int SKID = 2,
    localparam int CW   = $clog2(SKID + 1),
    localparam int PW   = (SKID > 1) ? $clog2(SKID) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] ONE_L = {{(CW-1){1'b0}}, 1'b1};

    logic [DW-1:0] mem_q [SKID];
    logic [DW-1:0] mem_d [SKID];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_s;

    // next-state for slots and fill level; a pop shifts toward slot 0 before the push lands
    always_comb begin
        pop_s = (cnt_q != {CW{1'b0}}) && out_ready;
        mem_d = mem_q;
        cnt_d = cnt_q;
        case ({in_valid, pop_s})
            2'b10: begin
                mem_d[PW'(cnt_q)] = in_data;
                cnt_d             = cnt_q + ONE_L;
            end
            2'b01: begin
                for (int i = 0; i < SKID - 1; i++) mem_d[i] = mem_q[i+1];
                cnt_d = cnt_q - ONE_L;
            end
            2'b11: begin
                for (int i = 0; i < SKID - 1; i++) mem_d[i] = mem_q[i+1];
                mem_d[PW'(cnt_q - ONE_L)] = in_data;
                cnt_d                     = cnt_q;
            end
            default: begin
                mem_d = mem_q;
                cnt_d = cnt_q;
            end
        endcase
    end

    // slot and level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID; i++) mem_q[i] <= {DW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != {CW{1'b0}});
    assign out_data  = mem_q[0];
    assign count     = cnt_q;
endmodule

// File: rtl/fifo_stream_adapter.sv
// Adapts valid/ready write and read streams onto the ring FIFO's single en/r_w command port.
module fifo_stream_adapter #(
    parameter  int DW    = 32,
    parameter  int DEPTH = fifo_pkg::DEPTH,
    parameter  int SKID  = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          fifo_reset,
    output logic          fifo_en,
    output logic          fifo_r_w,
    output logic [DW-1:0] fifo_in,
    input  logic [DW-1:0] fifo_out,
    output logic [CW-1:0] count
);
    import fifo_pkg::*;

    localparam int              SCW     = $clog2(SKID + 1);
    localparam logic [CW-1:0]   DEPTH_L = DEPTH[CW-1:0];
    localparam logic [CW-1:0]   ONE_L   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [SCW:0]    SKID_L  = SKID[SCW:0];

    adapter_state_e state_q, state_d;
    prio_e          prio_q, prio_d;
    logic           rel_q, rel_d;
    logic           fifo_reset_q, fifo_reset_d;
    logic [CW-1:0]  count_q, count_d;
    logic           inflight_q, inflight_d;
    logic           write_ok_s, read_ok_s, issue_w_s, issue_r_s;
    logic [SCW-1:0] skid_cnt_s;
    logic [SCW:0]   credit_s;

    // arbitration, occupancy and reset-release sequencing
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        rel_d        = rel_q;
        fifo_reset_d = fifo_reset_q;
        count_d      = count_q;
        inflight_d   = inflight_q;
        write_ok_s   = 1'b0;
        read_ok_s    = 1'b0;
        issue_w_s    = 1'b0;
        issue_r_s    = 1'b0;
        // a read is only launched if its word is guaranteed a skid slot, ignoring any same-cycle pop
        credit_s     = {1'b0, skid_cnt_s} + {{SCW{1'b0}}, inflight_q};
        case (state_q)
            INIT: begin
                rel_d      = 1'b1;
                inflight_d = 1'b0;
                if (rel_q) begin
                    state_d      = RUN;
                    fifo_reset_d = 1'b0;
                end else begin
                    state_d      = INIT;
                    fifo_reset_d = 1'b1;
                end
            end
            RUN: begin
                write_ok_s = wr_valid && (count_q < DEPTH_L);
                read_ok_s  = (count_q != {CW{1'b0}}) && (credit_s < SKID_L);
                if (write_ok_s && read_ok_s) begin
                    issue_w_s = (prio_q == PRIO_WRITE);
                    issue_r_s = (prio_q == PRIO_READ);
                    prio_d    = (prio_q == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
                end else begin
                    issue_w_s = write_ok_s;
                    issue_r_s = read_ok_s;
                    prio_d    = prio_q;
                end
                case ({issue_w_s, issue_r_s})
                    2'b10:   count_d = count_q + ONE_L;
                    2'b01:   count_d = count_q - ONE_L;
                    default: count_d = count_q;
                endcase
                inflight_d = issue_r_s;
            end
            default: begin
                state_d      = INIT;
                fifo_reset_d = 1'b1;
            end
        endcase
    end

    // adapter state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= INIT;
            prio_q       <= PRIO_WRITE;
            rel_q        <= 1'b0;
            fifo_reset_q <= 1'b1;
            count_q      <= {CW{1'b0}};
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            rel_q        <= rel_d;
            fifo_reset_q <= fifo_reset_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
        end
    end

    skid_buffer #(.DW(DW), .SKID(SKID)) u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (inflight_q),
        .in_data   (fifo_out),
        .out_ready (rd_ready),
        .out_valid (rd_valid),
        .out_data  (rd_data),
        .count     (skid_cnt_s)
    );

    assign wr_ready   = issue_w_s;
    assign fifo_en    = issue_w_s || issue_r_s;
    assign fifo_r_w   = issue_w_s;
    assign fifo_in    = wr_data;
    assign fifo_reset = fifo_reset_q;
    assign count      = count_q;
endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter with a behavioural ring-FIFO model and a write-order scoreboard.
module tb_fifo_stream_adapter;
    import fifo_pkg::*;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic          fifo_reset, fifo_en, fifo_r_w;
    word_t         wr_data, rd_data, fifo_in;
    word_t         fifo_out = 32'h0;
    logic [CW-1:0] count;

    int    checks = 0;
    int    errors = 0;
    word_t sb[$];
    word_t fq[$];

    always #5 clk = ~clk;

    fifo_stream_adapter dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .fifo_reset(fifo_reset),
        .fifo_en(fifo_en), .fifo_r_w(fifo_r_w), .fifo_in(fifo_in), .fifo_out(fifo_out), .count(count)
    );

    fifo_stream_adapter_chk #(.DEPTH(7)) u_chk (.clk(clk), .reset(reset), .count(count));

    // ring FIFO model: registered read data, zero on idle/write cycles
    always @(posedge clk) begin
        if (fifo_reset) begin
            fq.delete();
            fifo_out <= 32'h0;
        end else if (fifo_en && fifo_r_w) begin
            fq.push_back(fifo_in);
            fifo_out <= 32'h0;
        end else if (fifo_en && fq.size() > 0) begin
            fifo_out <= fq.pop_front();
        end else begin
            fifo_out <= 32'h0;
        end
    end

    // scoreboard: every accepted upstream word is expected downstream in order
    always @(posedge clk) begin
        if (!reset) sb.delete();
        else if (wr_valid && wr_ready) sb.push_back(wr_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        #1;
        checks++; if (fifo_reset !== 1'b1) begin errors++; $display("FAIL rst_fifo_reset: got %b expected 1", fifo_reset); end
        checks++; if (fifo_en !== 1'b0) begin errors++; $display("FAIL rst_fifo_en: got %b expected 0", fifo_en); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %b expected 0", wr_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_0000;
        reset    = 1'b1;
        #1;
        checks++; if (fifo_en !== 1'b0) begin errors++; $display("FAIL init0_fifo_en: got %b expected 0", fifo_en); end
        tick();
        #1;
        checks++; if (fifo_reset !== 1'b1) begin errors++; $display("FAIL init1_fifo_reset: got %b expected 1", fifo_reset); end
        checks++; if (fifo_en !== 1'b0) begin errors++; $display("FAIL init1_fifo_en: got %b expected 0", fifo_en); end
        tick();
        checks++; if (fifo_reset !== 1'b0) begin errors++; $display("FAIL run_fifo_reset: got %b expected 0", fifo_reset); end
        wr_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL run_count: got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL run_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL init_no_write: got %0d accepted expected 0", sb.size()); end
    endtask

    task automatic test_fill_drain();
        word_t w [3] = '{32'h11, 32'h22, 32'h33};
        word_t exp;
        logic  acc;
        rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1;
            wr_data  = w[k];
            acc      = 1'b0;
            for (int c = 0; c < 10 && !acc; c++) begin
                #1;
                acc = wr_ready;
                if (acc) begin
                    checks++; if (fifo_in !== w[k]) begin errors++; $display("FAIL fill_fifo_in: got %h expected %h", fifo_in, w[k]); end
                end
                tick();
            end
            checks++; if (!acc) begin errors++; $display("FAIL fill_accept_timeout: got none expected %h accepted", w[k]); end
        end
        wr_valid = 1'b0;
        repeat (6) tick();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL fill_count: got %0d expected 1", count); end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h11) begin errors++; $display("FAIL fill_head: got %b/%h expected 1/11", rd_valid, rd_data); end
        rd_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            #1;
            if (rd_valid) begin
                exp = sb.pop_front();
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL fill_order: got %h expected %h", rd_data, exp); end
            end
            tick();
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL fill_drain_timeout: got %0d left expected 0", sb.size()); end
        checks++; if (count !== 3'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: got %0d/%b expected 0/0", count, rd_valid); end
        rd_ready = 1'b0;
    endtask

    task automatic test_full();
        int    n_acc = 0;
        word_t exp;
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            wr_data = 32'hA000_0000 + n_acc;
            #1;
            if (wr_ready) n_acc++;
            tick();
        end
        #1;
        checks++; if (n_acc != 9) begin errors++; $display("FAIL full_accepted: got %0d expected 9", n_acc); end
        checks++; if (count !== 3'd7) begin errors++; $display("FAIL full_count: got %0d expected 7", count); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
        checks++; if (fifo_en !== 1'b0) begin errors++; $display("FAIL full_fifo_en: got %b expected 0", fifo_en); end
        checks++; if (rd_data !== 32'hA000_0000) begin errors++; $display("FAIL full_head: got %h expected a0000000", rd_data); end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int c = 0; c < 60 && sb.size() > 0; c++) begin
            #1;
            if (rd_valid) begin
                exp = sb.pop_front();
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL full_order: got %h expected %h", rd_data, exp); end
            end
            tick();
        end
        checks++; if (sb.size() != 0 || count !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d left count %0d expected 0/0", sb.size(), count); end
        rd_ready = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [4:0] exp_rw = 5'b01011;
        word_t      exp;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            wr_data = 32'hB0 + c;
            #1;
            checks++; if (fifo_en !== 1'b1 || fifo_r_w !== exp_rw[c]) begin errors++; $display("FAIL arb_cmd%0d: got en %b rw %b expected en 1 rw %b", c, fifo_en, fifo_r_w, exp_rw[c]); end
            if (rd_valid) begin
                exp = sb.pop_front();
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL arb_order: got %h expected %h", rd_data, exp); end
            end
            tick();
        end
        wr_valid = 1'b0;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            #1;
            if (rd_valid) begin
                exp = sb.pop_front();
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL arb_drain: got %h expected %h", rd_data, exp); end
            end
            tick();
        end
        checks++; if (sb.size() != 0 || count !== 3'd0) begin errors++; $display("FAIL arb_empty: got %0d left count %0d expected 0/0", sb.size(), count); end
        rd_ready = 1'b0;
    endtask

    task automatic test_throughput();
        int    delivered = 0;
        logic  extra = 1'b0;
        word_t exp;
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int c = 0; c < 30 && delivered < 5; c++) begin
            wr_data = 32'hC0 + delivered;
            #1;
            if (wr_ready) delivered++;
            tick();
        end
        wr_valid = 1'b0;
        repeat (4) tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL tp_preload: got %0d expected 3", count); end
        delivered = 0;
        rd_ready  = 1'b1;
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            #1;
            if (rd_valid) begin
                exp = sb.pop_front();
                delivered++;
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL tp_order: got %h expected %h", rd_data, exp); end
            end
            tick();
        end
        checks++; if (delivered != 5) begin errors++; $display("FAIL tp_delivered: got %0d expected 5", delivered); end
        for (int c = 0; c < 4; c++) begin
            #1;
            extra = extra | rd_valid;
            tick();
        end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL tp_duplicate: got rd_valid %b expected 0", extra); end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int    n_acc = 0;
        logic  stale = 1'b0;
        word_t exp;
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int c = 0; c < 30 && n_acc < 6; c++) begin
            wr_data = 32'hD0 + n_acc;
            #1;
            if (wr_ready) n_acc++;
            tick();
        end
        wr_valid = 1'b0;
        repeat (5) tick();
        checks++; if (count !== 3'd4 || rd_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill: got %0d/%b expected 4/1", count, rd_valid); end
        #2;
        reset    = 1'b0;
        wr_valid = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got %0d/%b expected 0/0", count, rd_valid); end
        checks++; if (fifo_reset !== 1'b1 || fifo_en !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL mid_async_cmd: got %b%b%b expected 100", fifo_reset, fifo_en, wr_ready); end
        tick();
        tick();
        reset    = 1'b1;
        wr_valid = 1'b0;
        tick();
        tick();
        checks++; if (fifo_reset !== 1'b0 || count !== 3'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL mid_reinit: got %b/%0d/%b expected 0/0/0", fifo_reset, count, rd_valid); end
        rd_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            stale = stale | rd_valid;
            tick();
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL mid_stale: got rd_valid %b expected 0", stale); end
        wr_valid = 1'b1;
        wr_data  = 32'hAB;
        for (int c = 0; c < 5 && sb.size() == 0; c++) tick();
        wr_valid = 1'b0;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            #1;
            if (rd_valid) begin
                exp = sb.pop_front();
                checks++; if (rd_data !== 32'hAB) begin errors++; $display("FAIL mid_fresh: got %h expected ab (sb %h)", rd_data, exp); end
            end
            tick();
        end
        checks++; if (sb.size() != 0 || count !== 3'd0) begin errors++; $display("FAIL mid_fresh_drain: got %0d left count %0d expected 0/0", sb.size(), count); end
    endtask

    initial begin
        reset    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wr_data  = 32'h0;
        test_reset();
        test_fill_drain();
        test_full();
        test_arbitration();
        test_throughput();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
